// File: rtl/motor_speed_ctrl.sv
// -----------------------------------------------------------------------------
// motor_speed_ctrl
//
// Closed-loop speed controller for the motor1 drive. It compares the rpm
// sample stream from encoder_to_rpm against a commanded setpoint. The block
// runs a soft-start (RAMP), then proportional regulation (REGULATE), and can
// trip into a latched stall FAULT. It drives the H-bridge with an 8-bit PWM
// whose duty is double-buffered, so the output never glitches mid-period.
//
// Optional feature macro: MOTOR_STALL_DETECT_EN
//   defined   : stall counter and FAULT state are built.
//   undefined : no stall counter, FAULT is unreachable, fault is tied low.
//
// Ports:
//   cclk       in   1  system clock, rising edge
//   rst        in   1  synchronous active-high reset
//   enable     in   1  run request (level); low forces IDLE next cycle
//   setpoint   in   8  target rpm
//   rpm        in   8  measured rpm, valid only with rpm_valid
//   rpm_valid  in   1  one-cycle sample strobe
//   duty       out  8  regulator duty 0..255
//   pwm        out  1  bridge drive, high for duty/256 of each period
//   state      out  2  0=IDLE 1=RAMP 2=REGULATE 3=FAULT
//   fault      out  1  high while in FAULT
// -----------------------------------------------------------------------------
module motor_speed_ctrl #(
    parameter int SHIFT         = 2,
    parameter int MAX_STEP      = 8,
    parameter int RAMP_DIV      = 1024,
    parameter int STALL_SAMPLES = 4,
    parameter int STALL_DUTY    = 128
) (
    input  logic       cclk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] setpoint,
    input  logic [7:0] rpm,
    input  logic       rpm_valid,
    output logic [7:0] duty,
    output logic       pwm,
    output logic [1:0] state,
    output logic       fault
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RAMP     = 2'd1;
    localparam logic [1:0] ST_REGULATE = 2'd2;
    localparam logic [1:0] ST_FAULT    = 2'd3;

    localparam int               DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    localparam logic signed [8:0] STEP_HI = 9'(MAX_STEP);
    localparam logic signed [8:0] STEP_LO = 9'(-MAX_STEP);

    // Reject parameter sets the datapath widths cannot represent.
    if (RAMP_DIV < 1 || MAX_STEP < 0 || MAX_STEP > 255 || SHIFT < 0 || SHIFT > 8 ||
        STALL_SAMPLES < 1 || STALL_DUTY < 0 || STALL_DUTY > 255) begin : g_bad_cfg
        $error("motor_speed_ctrl: parameter out of supported range");
    end

    logic [DIV_W-1:0]  ramp_cnt;
    logic [DIV_W-1:0]  ramp_next;
    logic [1:0]        state_next;
    logic [7:0]        duty_next;
    logic              fault_next;
    logic              stall_trip;

    logic signed [8:0] err;
    logic signed [8:0] step_raw;
    logic signed [8:0] step;
    logic signed [9:0] sum;
    logic [7:0]        reg_duty;

    logic [7:0]        pwm_cnt;
    logic [7:0]        pwm_cnt_next;
    logic [7:0]        shadow;
    logic [7:0]        shadow_next;
    logic              pwm_next;

    // Speed error is formed with a zero-extended sign bit so 0..255 both fit.
    assign err      = $signed({1'b0, setpoint}) - $signed({1'b0, rpm});
    assign step_raw = err >>> SHIFT;

    // Clamp the proportional step and saturate the updated duty to 0..255.
    always_comb begin
        step     = step_raw;
        reg_duty = duty;
        if (step_raw > STEP_HI) begin
            step = STEP_HI;
        end else if (step_raw < STEP_LO) begin
            step = STEP_LO;
        end else begin
            step = step_raw;
        end
        sum = $signed({2'b00, duty}) + $signed({step[8], step});
        if (sum[9]) begin
            reg_duty = 8'd0;
        end else if (sum[8]) begin
            reg_duty = 8'd255;
        end else begin
            reg_duty = sum[7:0];
        end
    end

`ifdef MOTOR_STALL_DETECT_EN
    localparam int                 STALL_W      = $clog2(STALL_SAMPLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST   = STALL_W'(STALL_SAMPLES);
    localparam logic [7:0]         STALL_DUTY_V = 8'(STALL_DUTY);

    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_inc;
    logic [STALL_W-1:0] stall_upd;
    logic [STALL_W-1:0] stall_next;
    logic               active;

    assign active    = (state == ST_RAMP) || (state == ST_REGULATE);
    assign stall_inc = stall_cnt + STALL_W'(1);

    // A zero-rpm sample only counts as stalled while the bridge is driven hard.
    always_comb begin
        stall_upd  = stall_cnt;
        stall_trip = 1'b0;
        if (rpm_valid && active) begin
            if ((rpm == 8'd0) && (duty >= STALL_DUTY_V)) begin
                stall_upd  = stall_inc;
                stall_trip = (stall_inc == STALL_LAST);
            end else begin
                stall_upd  = {STALL_W{1'b0}};
                stall_trip = 1'b0;
            end
        end else begin
            stall_upd  = stall_cnt;
            stall_trip = 1'b0;
        end
    end

    // Stall counter runs only in RAMP/REGULATE; it freezes in FAULT.
    always_comb begin
        stall_next = stall_cnt;
        if (!enable || (state == ST_IDLE)) begin
            stall_next = {STALL_W{1'b0}};
        end else if (active) begin
            stall_next = stall_upd;
        end else begin
            stall_next = stall_cnt;
        end
    end

    // Stall counter register.
    always_ff @(posedge cclk) begin
        if (rst) begin
            stall_cnt <= {STALL_W{1'b0}};
        end else begin
            stall_cnt <= stall_next;
        end
    end
`else
    assign stall_trip = 1'b0;
`endif

    // Mode sequencing, soft-start ramp and duty update.
    always_comb begin
        state_next = state;
        duty_next  = duty;
        ramp_next  = ramp_cnt;
        if (!enable) begin
            state_next = ST_IDLE;
            duty_next  = 8'd0;
            ramp_next  = {DIV_W{1'b0}};
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_RAMP;
                    duty_next  = 8'd0;
                    ramp_next  = {DIV_W{1'b0}};
                end
                ST_RAMP: begin
                    if (stall_trip) begin
                        state_next = ST_FAULT;
                        duty_next  = 8'd0;
                        ramp_next  = {DIV_W{1'b0}};
                    end else if (rpm_valid && (rpm >= (setpoint >> 1))) begin
                        // Handover beats a coincident divider tick.
                        state_next = ST_REGULATE;
                        ramp_next  = {DIV_W{1'b0}};
                    end else if (ramp_cnt == DIV_LAST) begin
                        ramp_next = {DIV_W{1'b0}};
                        duty_next = (duty == 8'd255) ? 8'd255 : duty + 8'd1;
                    end else begin
                        ramp_next = ramp_cnt + DIV_W'(1);
                    end
                end
                ST_REGULATE: begin
                    if (stall_trip) begin
                        state_next = ST_FAULT;
                        duty_next  = 8'd0;
                    end else if (rpm_valid) begin
                        duty_next = reg_duty;
                    end else begin
                        duty_next = duty;
                    end
                end
`ifdef MOTOR_STALL_DETECT_EN
                ST_FAULT: begin
                    state_next = ST_FAULT;
                    duty_next  = 8'd0;
                end
`endif
                default: begin
                    state_next = ST_IDLE;
                    duty_next  = 8'd0;
                    ramp_next  = {DIV_W{1'b0}};
                end
            endcase
        end
`ifdef MOTOR_STALL_DETECT_EN
        fault_next = (state_next == ST_FAULT);
`else
        fault_next = 1'b0;
`endif
    end

    // Control state registers.
    always_ff @(posedge cclk) begin
        if (rst) begin
            state    <= ST_IDLE;
            duty     <= 8'd0;
            ramp_cnt <= {DIV_W{1'b0}};
            fault    <= 1'b0;
        end else begin
            state    <= state_next;
            duty     <= duty_next;
            ramp_cnt <= ramp_next;
            fault    <= fault_next;
        end
    end

    // The shadow reloads on the last count so the new duty starts at count 0;
    // pwm is registered from next-cycle values, so it equals (counter < shadow).
    assign pwm_cnt_next = pwm_cnt + 8'd1;
    assign shadow_next  = (pwm_cnt == 8'd255) ? duty : shadow;
    assign pwm_next     = (pwm_cnt_next < shadow_next);

    // Free-running PWM period counter, duty shadow and output flop.
    always_ff @(posedge cclk) begin
        if (rst) begin
            pwm_cnt <= 8'd0;
            shadow  <= 8'd0;
            pwm     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt_next;
            shadow  <= shadow_next;
            pwm     <= pwm_next;
        end
    end

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_motor_speed_ctrl
//
// Directed bench for motor_speed_ctrl. Stimulus pushes hand-computed
// expectations into a scoreboard queue; a negedge monitor pops and compares
// them against the registered outputs. PWM high-time per period is measured
// separately and compared against an expectation queue.
// Stall checks are built only when MOTOR_STALL_DETECT_EN is defined.
// -----------------------------------------------------------------------------
module tb_motor_speed_ctrl;

    logic       cclk;
    logic       rst;
    logic       enable;
    logic [7:0] setpoint;
    logic [7:0] rpm;
    logic       rpm_valid;
    logic [7:0] duty;
    logic       pwm;
    logic [1:0] state;
    logic       fault;

    int checks = 0;
    int errors = 0;
    int model_duty = 0;

    string      q_name[$];
    logic [7:0] q_duty[$];
    logic [1:0] q_state[$];
    logic       q_fault[$];
    logic       q_cpwm[$];
    logic       q_pwm[$];
    int         pwm_exp_q[$];

    motor_speed_ctrl dut (
        .cclk      (cclk),
        .rst       (rst),
        .enable    (enable),
        .setpoint  (setpoint),
        .rpm       (rpm),
        .rpm_valid (rpm_valid),
        .duty      (duty),
        .pwm       (pwm),
        .state     (state),
        .fault     (fault)
    );

    // 10 ns clock.
    initial begin
        cclk = 1'b0;
        forever #5 cclk = ~cclk;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard monitor: compares every pending expectation at the negedge.
    always @(negedge cclk) begin : monitor
        string      nm;
        logic [7:0] ed;
        logic [1:0] es;
        logic       ef;
        logic       ecp;
        logic       ep;
        logic       ok;
        while (q_name.size() > 0) begin
            nm  = q_name.pop_front();
            ed  = q_duty.pop_front();
            es  = q_state.pop_front();
            ef  = q_fault.pop_front();
            ecp = q_cpwm.pop_front();
            ep  = q_pwm.pop_front();
            ok  = (duty === ed) && (state === es) && (fault === ef) && (!ecp || (pwm === ep));
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s: got duty=%0d state=%0d fault=%0b pwm=%0b, expected duty=%0d state=%0d fault=%0b pwm=%0b (pwm checked=%0b)",
                         nm, duty, state, fault, pwm, ed, es, ef, ep, ecp);
            end
        end
    end

    // Waits one rising edge, then queues the expected post-edge outputs.
    task automatic expect_cycle(input string nm, input logic [7:0] d, input logic [1:0] s,
                                input logic f, input logic cp, input logic p);
        @(posedge cclk);
        q_name.push_back(nm);
        q_duty.push_back(d);
        q_state.push_back(s);
        q_fault.push_back(f);
        q_cpwm.push_back(cp);
        q_pwm.push_back(p);
        @(negedge cclk);
    endtask

    // One rpm_valid strobe; called at a negedge.
    task automatic drive_sample(input logic [7:0] sp, input logic [7:0] r, input string nm,
                                input logic [7:0] d, input logic [1:0] s, input logic f);
        setpoint  = sp;
        rpm       = r;
        rpm_valid = 1'b1;
        expect_cycle(nm, d, s, f, 1'b0, 1'b0);
        rpm_valid = 1'b0;
    endtask

    // Steers duty in REGULATE using errors that are exact multiples of 4.
    task automatic walk_to(input int target);
        int d;
        while (model_duty != target) begin
            d = target - model_duty;
            if (d > 8) d = 8;
            else if (d < -8) d = -8;
            model_duty = model_duty + d;
            if (d > 0) drive_sample(8'd200, 8'(200 - 4 * d), "walk_up", 8'(model_duty), 2'd2, 1'b0);
            else       drive_sample(8'd100, 8'(100 - 4 * d), "walk_down", 8'(model_duty), 2'd2, 1'b0);
        end
    endtask

    // Counts pwm high samples over one 256-cycle period starting now.
    task automatic measure_period(output int hi);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (pwm === 1'b1) hi++;
            @(negedge cclk);
        end
    endtask

    // Aligns to the first cycle of a PWM period (pwm low->high).
    task automatic sync_pwm_rise(output bit ok);
        int n;
        n = 0;
        while (pwm !== 1'b0 && n < 600) begin @(negedge cclk); n++; end
        while (pwm !== 1'b1 && n < 600) begin @(negedge cclk); n++; end
        ok = (n < 600);
    endtask

    initial begin : stimulus
        bit ok;
        int hi_a;
        int hi_b;
        int exp_p;
        rst       = 1'b1;
        enable    = 1'b0;
        setpoint  = 8'd0;
        rpm       = 8'd0;
        rpm_valid = 1'b0;

        // Reset state.
        expect_cycle("reset", 8'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;

        // Setpoint 0: first sample hands over, and wins over a coincident ramp tick.
        enable   = 1'b1;
        setpoint = 8'd0;
        expect_cycle("idle_to_ramp", 8'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        repeat (1023) @(posedge cclk);
        @(negedge cclk);
        drive_sample(8'd0, 8'd0, "sp0_handover_no_tick", 8'd0, 2'd2, 1'b0);

        // Enable low returns to IDLE; samples are ignored there.
        enable = 1'b0;
        expect_cycle("enable_low_idle", 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        drive_sample(8'd10, 8'd200, "idle_ignores_sample", 8'd0, 2'd0, 1'b0);

        // Soft-start: 5 x RAMP_DIV cycles give duty 5.
        enable   = 1'b1;
        setpoint = 8'd100;
        expect_cycle("softstart_enter", 8'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        repeat (5119) @(posedge cclk);
        @(negedge cclk);
        expect_cycle("softstart_duty5", 8'd5, 2'd1, 1'b0, 1'b0, 1'b0);
        drive_sample(8'd100, 8'd50, "ramp_to_regulate", 8'd5, 2'd2, 1'b0);
        model_duty = 5;

        // Regulation clamp from duty 100, setpoint 200.
        walk_to(100);
        drive_sample(8'd200, 8'd0,   "clamp_pos", 8'd108, 2'd2, 1'b0);
        drive_sample(8'd200, 8'd196, "small_step", 8'd109, 2'd2, 1'b0);
        drive_sample(8'd200, 8'd255, "clamp_neg", 8'd101, 2'd2, 1'b0);
        model_duty = 101;

        // PWM shadowing: duty 64 -> 192 mid-period.
        walk_to(64);
        sync_pwm_rise(ok);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL pwm_sync: pwm=%0b, expected a low->high transition within 600 cycles", pwm);
        end else begin
            pwm_exp_q.push_back(64);
            pwm_exp_q.push_back(192);
            fork
                begin
                    measure_period(hi_a);
                    measure_period(hi_b);
                end
                begin
                    repeat (10) @(negedge cclk);
                    walk_to(192);
                end
            join
            exp_p = pwm_exp_q.pop_front();
            checks++;
            if (hi_a != exp_p) begin
                errors++;
                $display("FAIL pwm_period_old: high cycles=%0d, expected %0d", hi_a, exp_p);
            end
            exp_p = pwm_exp_q.pop_front();
            checks++;
            if (hi_b != exp_p) begin
                errors++;
                $display("FAIL pwm_period_new: high cycles=%0d, expected %0d", hi_b, exp_p);
            end
        end
        model_duty = 192;

        // Saturation at both ends.
        walk_to(252);
        drive_sample(8'd255, 8'd0, "sat_high", 8'd255, 2'd2, 1'b0);
        model_duty = 255;
        walk_to(3);
        drive_sample(8'd0, 8'd255, "sat_low", 8'd0, 2'd2, 1'b0);
        model_duty = 0;

        // Reset in the middle of REGULATE.
        walk_to(90);
        rst = 1'b1;
        expect_cycle("reset_mid_regulate", 8'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        expect_cycle("post_reset_ramp", 8'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        model_duty = 0;

`ifdef MOTOR_STALL_DETECT_EN
        // Stall detection: a non-zero sample at count 3 clears the counter.
        drive_sample(8'd200, 8'd150, "stall_enter_reg", 8'd0, 2'd2, 1'b0);
        walk_to(200);
        drive_sample(8'd200, 8'd0,   "stall_1", 8'd208, 2'd2, 1'b0);
        drive_sample(8'd200, 8'd0,   "stall_2", 8'd216, 2'd2, 1'b0);
        drive_sample(8'd200, 8'd0,   "stall_3", 8'd224, 2'd2, 1'b0);
        drive_sample(8'd200, 8'd200, "stall_clear", 8'd224, 2'd2, 1'b0);
        drive_sample(8'd200, 8'd0,   "stall_again_1", 8'd232, 2'd2, 1'b0);
        drive_sample(8'd200, 8'd0,   "stall_again_2", 8'd240, 2'd2, 1'b0);
        drive_sample(8'd200, 8'd0,   "stall_again_3", 8'd248, 2'd2, 1'b0);
        drive_sample(8'd200, 8'd0,   "stall_trip", 8'd0, 2'd3, 1'b1);
        drive_sample(8'd200, 8'd0,   "fault_ignores_sample", 8'd0, 2'd3, 1'b1);
        expect_cycle("fault_holds", 8'd0, 2'd3, 1'b1, 1'b0, 1'b0);
`endif

        // Leaving any active state via enable low.
        enable = 1'b0;
        expect_cycle("final_enable_low", 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20 && q_name.size() > 0; i++) @(negedge cclk);
        if (q_name.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_name.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
